alu_issue_ctrl: RTL and testbench

Execute-stage issue block that drives the ALU32Bit operand/control interface (ALUControl, A, B). It decodes MIPS opcode/funct/rt fields into the 4-bit ALU operation code and selects and extends the operands. Results pass through a 2-entry valid/ready skid buffer, so upstream decode and the execute stage can stall independently. Flush support lets the pipeline squash wrong-path operations.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_op_decode.sv | 83 ++++++++
 rtl/alu_issue_ctrl.sv | 108 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU operation codes, MIPS field encodings
// and the buffered entry format.
package alu_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_TAG_W  = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SGT  = 4'b0110;
    localparam logic [3:0] ALU_RSVD = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_GTEZ = 4'b1011;
    localparam logic [3:0] ALU_LTZ  = 4'b1100;
    localparam logic [3:0] ALU_GTZ  = 4'b1101;
    localparam logic [3:0] ALU_LTEZ = 4'b1110;
    localparam logic [3:0] ALU_MUL  = 4'b1111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_MUL    = 6'b011100;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MUL  = 6'b000010;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef struct packed {
        logic [3:0]            ctrl;
        logic [PKG_DATA_W-1:0] a;
        logic [PKG_DATA_W-1:0] b;
        logic [PKG_TAG_W-1:0]  tag;
        logic                  illegal;
    } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of MIPS opcode/funct/rt fields into an ALU entry:
// operation code plus selected and extended operands.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int TAG_W  = PKG_TAG_W
) (
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_shamt,
    input  logic [15:0]       i_imm,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [TAG_W-1:0]  i_tag,
    output entry_t            o_entry
);

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_shamt;

    assign w_sext  = {{(DATA_W-16){i_imm[15]}}, i_imm};
    assign w_zext  = {{(DATA_W-16){1'b0}}, i_imm};
    assign w_shamt = {{(DATA_W-5){1'b0}}, i_shamt};

    // Each matched encoding clears illegal; anything else keeps the
    // reserved code with zero operands.
    always_comb begin
        o_entry         = '0;
        o_entry.tag     = i_tag;
        o_entry.ctrl    = ALU_RSVD;
        o_entry.illegal = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_entry.illegal = 1'b0;
                o_entry.a       = i_rs_data;
                o_entry.b       = i_rt_data;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_entry.ctrl = ALU_ADD;
                    FN_SUB:          o_entry.ctrl = ALU_SUB;
                    FN_AND:          o_entry.ctrl = ALU_AND;
                    FN_OR:           o_entry.ctrl = ALU_OR;
                    FN_XOR:          o_entry.ctrl = ALU_XOR;
                    FN_NOR:          o_entry.ctrl = ALU_NOR;
                    FN_SLT:          o_entry.ctrl = ALU_SLT;
                    FN_SLL:  begin o_entry.ctrl = ALU_SLL; o_entry.a = i_rt_data; o_entry.b = w_shamt;   end
                    FN_SRL:  begin o_entry.ctrl = ALU_SRL; o_entry.a = i_rt_data; o_entry.b = w_shamt;   end
                    FN_SLLV: begin o_entry.ctrl = ALU_SLL; o_entry.a = i_rt_data; o_entry.b = i_rs_data; end
                    FN_SRLV: begin o_entry.ctrl = ALU_SRL; o_entry.a = i_rt_data; o_entry.b = i_rs_data; end
                    default: begin o_entry.illegal = 1'b1; o_entry.a = '0; o_entry.b = '0; end
                endcase
            end
            OP_MUL: begin
                if (i_funct == FN_MUL) begin
                    o_entry.ctrl = ALU_MUL; o_entry.a = i_rs_data; o_entry.b = i_rt_data; o_entry.illegal = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: begin
                o_entry.ctrl = ALU_ADD; o_entry.a = i_rs_data; o_entry.b = w_sext; o_entry.illegal = 1'b0;
            end
            OP_SLTI: begin o_entry.ctrl = ALU_SLT; o_entry.a = i_rs_data; o_entry.b = w_sext; o_entry.illegal = 1'b0; end
            OP_ANDI: begin o_entry.ctrl = ALU_AND; o_entry.a = i_rs_data; o_entry.b = w_zext; o_entry.illegal = 1'b0; end
            OP_ORI:  begin o_entry.ctrl = ALU_OR;  o_entry.a = i_rs_data; o_entry.b = w_zext; o_entry.illegal = 1'b0; end
            OP_XORI: begin o_entry.ctrl = ALU_XOR; o_entry.a = i_rs_data; o_entry.b = w_zext; o_entry.illegal = 1'b0; end
            OP_BEQ, OP_BNE: begin
                o_entry.ctrl = ALU_SUB; o_entry.a = i_rs_data; o_entry.b = i_rt_data; o_entry.illegal = 1'b0;
            end
            OP_BLEZ: begin o_entry.ctrl = ALU_LTEZ; o_entry.a = i_rs_data; o_entry.illegal = 1'b0; end
            OP_BGTZ: begin o_entry.ctrl = ALU_GTZ;  o_entry.a = i_rs_data; o_entry.illegal = 1'b0; end
            OP_REGIMM: begin
                if (i_rt == RT_BLTZ) begin
                    o_entry.ctrl = ALU_LTZ; o_entry.a = i_rs_data; o_entry.illegal = 1'b0;
                end else if (i_rt == RT_BGEZ) begin
                    o_entry.ctrl = ALU_GTEZ; o_entry.a = i_rs_data; o_entry.illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue block: decodes ops and holds them in a 2-entry
// valid/ready skid buffer in front of the ALU; head entry drives the ALU.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int TAG_W  = PKG_TAG_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Shamt,
    input  logic [15:0]       Imm,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic [TAG_W-1:0]  InTag,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [3:0]        ALUControl,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [TAG_W-1:0]  OutTag,
    output logic              Illegal
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t r_state;
    logic   r_in_ready;
    entry_t r_head;
    entry_t r_tail;
    entry_t w_dec;
    logic   w_accept;
    logic   w_pop;

    alu_op_decode #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_decode (
        .i_opcode  (Opcode),
        .i_funct   (Funct),
        .i_rt      (Rt),
        .i_shamt   (Shamt),
        .i_imm     (Imm),
        .i_rs_data (RsData),
        .i_rt_data (RtData),
        .i_tag     (InTag),
        .o_entry   (w_dec)
    );

    // Flush squashes the incoming op as well as the buffered ones.
    assign w_accept = InValid & r_in_ready & ~Flush;
    assign w_pop    = OutReady & (r_state != ST_EMPTY);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (Flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head  <= w_dec;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_dec;
                    end else if (w_accept) begin
                        r_tail     <= w_dec;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head     <= r_tail;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign InReady    = r_in_ready;
    assign OutValid   = (r_state != ST_EMPTY);
    assign ALUControl = r_head.ctrl;
    assign A          = r_head.a;
    assign B          = r_head.b;
    assign OutTag     = r_head.tag;
    assign Illegal    = r_head.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus randomized traffic
// checked against a queue model of the buffer and a table decode model.
module tb_alu_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [5:0]  Opcode = '0;
  logic [5:0]  Funct = '0;
  logic [4:0]  Rt = '0;
  logic [4:0]  Shamt = '0;
  logic [15:0] Imm = '0;
  logic [31:0] RsData = '0;
  logic [31:0] RtData = '0;
  logic [4:0]  InTag = '0;
  logic        Flush = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  OutTag;
  logic        Illegal;

  // expected entry: {tag[73:69], illegal[68], ctrl[67:64], a[63:32], b[31:0]}
  logic [73:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] op_tab [19] = '{6'b000000, 6'b000000, 6'b000000, 6'b000001, 6'b000100,
                              6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
                              6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b011100,
                              6'b100000, 6'b100011, 6'b101001, 6'b101011};
  logic [5:0] fn_tab [13] = '{6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b100000,
                              6'b100001, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                              6'b100111, 6'b101010, 6'b000011};

  always #5 Clk = ~Clk;

  alu_issue_ctrl #(.DATA_W(32), .TAG_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Funct(Funct), .Rt(Rt), .Shamt(Shamt), .Imm(Imm),
    .RsData(RsData), .RtData(RtData), .InTag(InTag), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .ALUControl(ALUControl),
    .A(A), .B(B), .OutTag(OutTag), .Illegal(Illegal)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decode table written straight from the instruction set rules.
  function automatic logic [73:0] ref_entry(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [4:0] rt, input logic [4:0] sh,
                                            input logic [15:0] imm, input logic [31:0] rs,
                                            input logic [31:0] rtd, input logic [4:0] tag);
    logic [3:0]  c;
    logic [31:0] a, b, sx, zx;
    logic        ill;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    c = 4'b0111; a = 0; b = 0; ill = 1'b1;
    case (op)
      6'b000000: begin
        ill = 1'b0; a = rs; b = rtd;
        case (fn)
          6'b100000, 6'b100001: c = 4'b0010;
          6'b100010: c = 4'b0011;
          6'b100100: c = 4'b0000;
          6'b100101: c = 4'b0001;
          6'b100110: c = 4'b1010;
          6'b100111: c = 4'b0101;
          6'b101010: c = 4'b0100;
          6'b000000: begin c = 4'b1000; a = rtd; b = {27'd0, sh}; end
          6'b000010: begin c = 4'b1001; a = rtd; b = {27'd0, sh}; end
          6'b000100: begin c = 4'b1000; a = rtd; b = rs; end
          6'b000110: begin c = 4'b1001; a = rtd; b = rs; end
          default: begin ill = 1'b1; a = 0; b = 0; end
        endcase
      end
      6'b011100: if (fn == 6'b000010) begin c = 4'b1111; a = rs; b = rtd; ill = 1'b0; end
      6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b100000, 6'b100001, 6'b101000, 6'b101001:
        begin c = 4'b0010; a = rs; b = sx; ill = 1'b0; end
      6'b001010: begin c = 4'b0100; a = rs; b = sx; ill = 1'b0; end
      6'b001100: begin c = 4'b0000; a = rs; b = zx; ill = 1'b0; end
      6'b001101: begin c = 4'b0001; a = rs; b = zx; ill = 1'b0; end
      6'b001110: begin c = 4'b1010; a = rs; b = zx; ill = 1'b0; end
      6'b000100, 6'b000101: begin c = 4'b0011; a = rs; b = rtd; ill = 1'b0; end
      6'b000110: begin c = 4'b1110; a = rs; ill = 1'b0; end
      6'b000111: begin c = 4'b1101; a = rs; ill = 1'b0; end
      6'b000001: begin
        if (rt == 5'd0) begin c = 4'b1100; a = rs; ill = 1'b0; end
        else if (rt == 5'd1) begin c = 4'b1011; a = rs; ill = 1'b0; end
      end
      default: ;
    endcase
    return {tag, ill, c, a, b};
  endfunction

  task automatic model_edge();
    bit ready_before;
    ready_before = (exp_q.size() < 2);
    if (Flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && OutReady) void'(exp_q.pop_front());
      if (InValid && ready_before)
        exp_q.push_back(ref_entry(Opcode, Funct, Rt, Shamt, Imm, RsData, RtData, InTag));
    end
  endtask

  task automatic check_outputs();
    logic [73:0] e;
    check_val("out_valid", OutValid, exp_q.size() != 0);
    check_val("in_ready", InReady, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check_val("ctrl", ALUControl, e[67:64]);
      check_val("a", A, e[63:32]);
      check_val("b", B, e[31:0]);
      check_val("tag", OutTag, e[73:69]);
      check_val("illegal", Illegal, e[68]);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                        input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] rs,
                        input logic [31:0] rtd, input logic [4:0] tag);
    Opcode = op; Funct = fn; Rt = rt; Shamt = sh; Imm = imm;
    RsData = rs; RtData = rtd; InTag = tag; InValid = 1'b1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #1 Reset = 1'b1;
    exp_q.delete();
    #1;
    check_val("rst_out_valid", OutValid, 1'b0);
    check_val("rst_in_ready", InReady, 1'b1);
    check_val("rst_ctrl", ALUControl, 4'b0000);
    check_val("rst_a", A, 32'd0);
    check_val("rst_b", B, 32'd0);
    check_val("rst_tag", OutTag, 5'd0);
    check_val("rst_illegal", Illegal, 1'b0);
    #1 Reset = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    do_reset();

    // addi with negative immediate
    OutReady = 1'b1;
    set_op(6'b001000, 6'd0, 5'd0, 5'd0, 16'hFFFD, 32'd5, 32'd0, 5'd3);
    tick();
    check_val("addi_ctrl", ALUControl, 4'b0010);
    check_val("addi_a", A, 32'd5);
    check_val("addi_b", B, 32'hFFFFFFFD);
    check_val("addi_ill", Illegal, 1'b0);
    InValid = 1'b0;
    tick();
    check_val("addi_drained", OutValid, 1'b0);

    // sll then sllv, in order
    set_op(6'b000000, 6'b000000, 5'd0, 5'd4, 16'h0, 32'd3, 32'd1, 5'd1);
    tick();
    check_val("sll_ctrl", ALUControl, 4'b1000);
    check_val("sll_a", A, 32'd1);
    check_val("sll_b", B, 32'd4);
    set_op(6'b000000, 6'b000100, 5'd0, 5'd4, 16'h0, 32'd3, 32'd1, 5'd2);
    tick();
    check_val("sllv_ctrl", ALUControl, 4'b1000);
    check_val("sllv_a", A, 32'd1);
    check_val("sllv_b", B, 32'd3);
    InValid = 1'b0;
    tick();

    // stall with three back-to-back andi ops
    OutReady = 1'b0;
    set_op(6'b001100, 6'd0, 5'd0, 5'd0, 16'h8000, 32'd7, 32'd0, 5'd1);
    tick();
    InTag = 5'd2;
    tick();
    InTag = 5'd3;
    tick();
    check_val("stall_in_ready", InReady, 1'b0);
    check_val("stall_head_b", B, 32'h00008000);
    check_val("stall_head_tag", OutTag, 5'd1);
    OutReady = 1'b1;
    tick();
    check_val("release_tag2", OutTag, 5'd2);
    tick();
    check_val("release_tag3", OutTag, 5'd3);
    InValid = 1'b0;
    tick();
    check_val("release_drained", OutValid, 1'b0);

    // REGIMM: bgez then an unassigned rt
    set_op(6'b000001, 6'd0, 5'd1, 5'd0, 16'h0, 32'h80000000, 32'd9, 5'd4);
    tick();
    check_val("gtez_ctrl", ALUControl, 4'b1011);
    check_val("gtez_b", B, 32'd0);
    Rt = 5'd3;
    tick();
    check_val("regimm_bad_ctrl", ALUControl, 4'b0111);
    check_val("regimm_bad_ill", Illegal, 1'b1);
    check_val("regimm_bad_a", A, 32'd0);
    InValid = 1'b0;
    tick();

    // flush while full with an incoming op
    OutReady = 1'b0;
    set_op(6'b001000, 6'd0, 5'd0, 5'd0, 16'h0001, 32'd10, 32'd0, 5'd10);
    tick();
    InTag = 5'd11;
    tick();
    check_val("pre_flush_full", InReady, 1'b0);
    Flush = 1'b1; InTag = 5'd12;
    tick();
    check_val("flush_out_valid", OutValid, 1'b0);
    check_val("flush_in_ready", InReady, 1'b1);
    Flush = 1'b0; InValid = 1'b0;
    tick();
    check_val("flush_no_ghost", OutValid, 1'b0);

    // flush with one entry and an acceptable incoming op
    set_op(6'b001101, 6'd0, 5'd0, 5'd0, 16'h00F0, 32'd1, 32'd0, 5'd13);
    tick();
    Flush = 1'b1; InTag = 5'd14;
    tick();
    check_val("flush1_out_valid", OutValid, 1'b0);
    Flush = 1'b0; InValid = 1'b0;

    // reset while full
    set_op(6'b001110, 6'd0, 5'd0, 5'd0, 16'h1234, 32'd2, 32'd0, 5'd15);
    tick();
    InTag = 5'd16;
    tick();
    InValid = 1'b0;
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Opcode  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 18)];
      Funct   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 12)];
      if (Opcode == 6'b011100 && $urandom_range(0, 1) == 1) Funct = 6'b000010;
      Rt      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      Shamt   = 5'($urandom);
      Imm     = 16'($urandom);
      RsData  = $urandom;
      RtData  = $urandom;
      InTag   = 5'($urandom);
      InValid = ($urandom_range(0, 2) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      Flush   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
